// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential BCD-to-binary converter using reverse double-dabble.
// Each iteration shifts the work register right by one bit. Any digit field
// in the upper 4*N_DIGITS bits that ends up >= 8 is then reduced by 3.
// After BIN_W iterations the low BIN_W bits hold the binary value.
//
// Ports:
//   CLOCK_50  system clock (rising edge)
//   reset     synchronous active-high reset
//   start     conversion request, sampled only while idle
//   bcd_in    packed BCD operand (digit 0 in [3:0]), captured on accept
//   bin_out   binary result, held until the next completion or reset
//   busy      conversion in progress
//   done      one-cycle pulse when bin_out updates
//   err       invalid-digit flag, qualified by done
//
// Optional: define BCD2BIN_DIGIT_CHECK_EN to reject operands with a digit > 9.
// A rejected operand completes one edge after acceptance with bin_out=0 and
// err=1. Without the macro, err is tied low and every operand runs the full
// algorithm.
module bcd2bin_seq #(
   parameter int N_DIGITS = 4,
   parameter int BIN_W    = 14
) (
   input  logic                    CLOCK_50,
   input  logic                    reset,
   input  logic                    start,
   input  logic [4*N_DIGITS-1:0]   bcd_in,
   output logic [BIN_W-1:0]        bin_out,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);

   localparam int WW = 4*N_DIGITS + BIN_W;
   localparam int CW = $clog2(BIN_W + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef BCD2BIN_DIGIT_CHECK_EN
   localparam logic [1:0] S_BAD   = 2'd2;
`endif

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [WW-1:0] work;
   logic [WW-1:0] shifted;
   logic [WW-1:0] nxt;

   // One iteration: logical shift right, then a per-digit -3 correction.
   // There is no borrow between digits.
   assign shifted = {1'b0, work[WW-1:1]};
   assign nxt[BIN_W-1:0] = shifted[BIN_W-1:0];

   genvar d;
   generate
      for (d = 0; d < N_DIGITS; d++) begin : g_dig
         // A field value of 8 or more is exactly the case where the top bit is set.
         assign nxt[BIN_W+4*d +: 4] = shifted[BIN_W+4*d+3]
                                     ? shifted[BIN_W+4*d +: 4] - 4'd3
                                     : shifted[BIN_W+4*d +: 4];
      end
   endgenerate

`ifdef BCD2BIN_DIGIT_CHECK_EN
   logic [N_DIGITS-1:0] dig_bad;
   logic                err_q;

   generate
      for (d = 0; d < N_DIGITS; d++) begin : g_chk
         assign dig_bad[d] = (bcd_in[4*d +: 4] > 4'd9);
      end
   endgenerate

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         work    <= '0;
         bin_out <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  work  <= {bcd_in, {BIN_W{1'b0}}};
                  cnt   <= '0;
                  busy  <= 1'b1;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                  state <= (|dig_bad) ? S_BAD : S_SHIFT;
`else
                  state <= S_SHIFT;
`endif
               end
            end
            S_SHIFT: begin
               work <= nxt;
               cnt  <= cnt + 1'b1;
               if (cnt == CW'(BIN_W-1)) begin
                  bin_out <= nxt[BIN_W-1:0];
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state   <= S_IDLE;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                  err_q   <= 1'b0;
`endif
               end
            end
`ifdef BCD2BIN_DIGIT_CHECK_EN
            S_BAD: begin
               bin_out <= '0;
               err_q   <= 1'b1;
               done    <= 1'b1;
               busy    <= 1'b0;
               state   <= S_IDLE;
            end
`endif
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd2bin_seq.sv
module tb_bcd2bin_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] bcd_in;
   logic [13:0] bin_out;
   logic        busy;
   logic        done;
   logic        err;

   int npass = 0;
   int ntot  = 0;

   bcd2bin_seq dut (
      .CLOCK_50 (clk),
      .reset    (reset),
      .start    (start),
      .bcd_in   (bcd_in),
      .bin_out  (bin_out),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Waits for done (bounded), starting from cycle 1 after the accepting edge.
   task automatic wait_done(output int n);
      n = 1;
      while (done !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run_conv(input string tag, input logic [15:0] bcd,
                           input logic [13:0] exp, input bit cv);
      int n;
      bcd_in = bcd;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      wait_done(n);
      chk({tag, "_lat"}, n, 15);
      if (cv) chk({tag, "_val"}, bin_out, exp);
      chk({tag, "_err"}, err, 1'b0);
      @(negedge clk);
      chk({tag, "_done_drop"}, done, 1'b0);
   endtask

   logic [15:0] ops  [3] = '{16'h0001, 16'h0010, 16'h0100};
   logic [13:0] exps [3] = '{14'd1, 14'd10, 14'd100};

   initial begin
      int n;
      int cnt_done;
      reset  = 1'b1;
      start  = 1'b0;
      bcd_in = 16'h0000;
      repeat (2) @(negedge clk);
      reset  = 1'b0;
      chk("rst_bin", bin_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);

      // Zero operand: busy for cycles 1..14, done in cycle 15.
      bcd_in = 16'h0000;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      for (int i = 1; i <= 14; i++) begin
         chk($sformatf("zero_busy_c%0d", i), {busy, done}, 2'b10);
         @(negedge clk);
      end
      chk("zero_done", done, 1);
      chk("zero_busy_off", busy, 0);
      chk("zero_val", bin_out, 0);
      chk("zero_err", err, 0);
      @(negedge clk);
      chk("zero_done_drop", done, 0);

      run_conv("c9999", 16'h9999, 14'h270F, 1'b1);
      run_conv("c1023", 16'h1023, 14'h03FF, 1'b1);
      run_conv("c0255", 16'h0255, 14'h00FF, 1'b1);

      // A start while busy is ignored, and the operand stays the captured one.
      bcd_in = 16'h0042;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      repeat (3) @(negedge clk);
      bcd_in = 16'h1111;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      n = 5;
      while (done !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("busy_start_lat", n, 15);
      chk("busy_start_val", bin_out, 14'd42);
      cnt_done = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done === 1'b1) cnt_done++;
      end
      chk("busy_start_no_second", cnt_done, 0);

      // With start held high, conversions run back-to-back.
      start  = 1'b1;
      bcd_in = ops[0];
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         wait_done(n);
         chk($sformatf("held%0d_lat", k), n, 15);
         chk($sformatf("held%0d_val", k), bin_out, exps[k]);
         if (k < 2) bcd_in = ops[k+1];
         else start = 1'b0;
         @(negedge clk);
      end
      chk("held_end_done", done, 0);
      chk("held_end_busy", busy, 0);

      // Reset in the middle of a conversion aborts it.
      bcd_in = 16'h5000;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      repeat (4) @(negedge clk);
      reset  = 1'b1;
      @(negedge clk);
      reset  = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_bin", bin_out, 0);
      chk("abort_done", done, 0);
      cnt_done = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done === 1'b1) cnt_done++;
      end
      chk("abort_no_done", cnt_done, 0);
      run_conv("c0007", 16'h0007, 14'd7, 1'b1);

`ifdef BCD2BIN_DIGIT_CHECK_EN
      bcd_in = 16'h0A12;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      chk("bad_c1", {busy, done}, 2'b10);
      @(negedge clk);
      chk("bad_done", done, 1);
      chk("bad_err", err, 1);
      chk("bad_bin", bin_out, 0);
      chk("bad_busy", busy, 0);
      @(negedge clk);
      chk("bad_done_drop", done, 0);
      run_conv("c0012", 16'h0012, 14'd12, 1'b1);
`else
      // Without the check an invalid digit runs the full algorithm with err low.
      run_conv("c0A12", 16'h0A12, 14'd0, 1'b0);
      run_conv("c0012", 16'h0012, 14'd12, 1'b1);
`endif

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
